btn_press_classifier: RTL and testbench
=======================================

# btn_press_classifier

Button front-end for the stopwatch datapath. It sits directly upstream of the stopwatch FSM, between the raw board buttons and the stopwatch's start/stop, lap and clear logic. For each of two raw push-buttons it synchronises and debounces the input, then classifies each press as short or long. It produces one-cycle SHORT_PRESS / LONG_PRESS pulses and a clean held level, so the stopwatch no longer needs its own edge detectors or 3 s hold counters.

## Interface
Parameters:
- CLK_FREQ, 125_000_000: system clock in Hz; TICK_DIV = CLK_FREQ/1000 clock cycles per 1 ms tick (CLK_FREQ must be a multiple of 1000, ≥ 2000).
- DEBOUNCE_MS, 20: number of consecutive stable ticks required to accept a level change (≥ 2).
- LONG_MS, 3000: number of held ticks before a long press is declared (≥ 2).

Ports:
- Reset: one clock; reset is synchronous and active-low.
- CLK  in  1  system clock.
- RST_N  in  1  synchronous active-low reset.
- BTN  in  2  raw asynchronous buttons (bit 0 = BTN0 start/stop/load, bit 1 = BTN1 lap/clear).
- BTN_LEVEL  out  2  debounced level per button.
- SHORT_PRESS  out  2  one-cycle pulse on debounced release of a press shorter than LONG_MS.
- LONG_PRESS  out  2  one-cycle pulse when a hold reaches LONG_MS ticks.

## Operation
- **Input synchroniser:** two-flop synchroniser per bit. The FSMs act only on the synchronised value `s`.
- **Prescaler:** counter runs 0..TICK_DIV-1 and wraps. `tick` is high for one cycle when the counter equals TICK_DIV-1.
- **Per-channel FSM:** states are IDLE, PRESS_DB, HELD, LONG_HELD, REL_DB. Each channel has two counters:
  - debounce count `dc`, width $clog2(DEBOUNCE_MS)+1;
  - hold count `hc`, width $clog2(LONG_MS)+1.
- **IDLE:** if `s`=1, go to PRESS_DB with `dc`=0.
- **PRESS_DB:**
  - `s`=0: return to IDLE; this is a glitch and produces no output.
  - On a tick with `s`=1, increment `dc`. When `dc` reaches DEBOUNCE_MS-1 on a tick, go to HELD, set BTN_LEVEL=1 and `hc`=0.
- **HELD:**
  - On each tick, increment `hc`. When `hc` reaches LONG_MS-1 on a tick, pulse LONG_PRESS and go to LONG_HELD.
  - `s`=0: go to REL_DB, record long flag = 0, `dc`=0.
- **LONG_HELD:** if `s`=0, go to REL_DB with long flag = 1 and `dc`=0. LONG_PRESS fires exactly once per press.
- **REL_DB:**
  - `hc` is frozen while in this state.
  - `s`=1: return to HELD or LONG_HELD according to the long flag. This is a bounce; it produces no output and does not restart `hc`.
  - On a tick with `s`=0, increment `dc`. At DEBOUNCE_MS-1, go to IDLE and set BTN_LEVEL=0. If the long flag is 0, pulse SHORT_PRESS in the same cycle.
- **Mutual exclusion:** for a given press, SHORT_PRESS and LONG_PRESS are mutually exclusive.
- **Channel independence:** the two channels are independent. Both may pulse in the same cycle.
- **Reset:** forces every channel to IDLE and clears the prescaler, synchroniser flops and counters. A press in progress is discarded and never pulses. A button still held after reset is re-debounced from scratch.

## Timing
- **Reset values:** BTN_LEVEL=2'b00, SHORT_PRESS=2'b00, LONG_PRESS=2'b00, tick=0.
- **Output registers:** all outputs are registered. Pulses are exactly one CLK wide.
- **Press latency:** from a stable raw edge to BTN_LEVEL rise is 2 synchroniser cycles plus a first tick that may be partial, plus DEBOUNCE_MS-1 further ticks. That is, between (DEBOUNCE_MS-1)·TICK_DIV+2 and DEBOUNCE_MS·TICK_DIV+3 cycles.
- **Long-press latency:** LONG_PRESS asserts LONG_MS ticks after BTN_LEVEL rises, ±1 tick for tick phase.
- **Short-press latency:** SHORT_PRESS asserts in the same cycle BTN_LEVEL falls, with the same latency rule as the rise.
- **Tick alignment:** a state change on a cycle where `tick`=1 does not count that tick for the new state.

## Structure
- **Shared package `stopwatch_pkg`:**
  - the channel state encoding localparams (IDLE=3'd0 … REL_DB=3'd4);
  - the TICK_DIV derivation;
  - button index constants BTN_SS=0 and BTN_LAP=1.
- **Sub-module `btn_channel`:** contains the synchroniser, FSM and the two counters for one bit. The top level instantiates it twice and drives the shared prescaler `tick` into both.

## Test plan
All scenarios use CLK_FREQ=4000 (TICK_DIV=4), DEBOUNCE_MS=3 and LONG_MS=10.
- **Reset:** hold RST_N=0 for 5 cycles with BTN=2'b11. All outputs must be 0. After release, BTN_LEVEL rises only after a fresh debounce of 10–15 cycles.
- **Glitch rejection:** BTN[0] high for 6 cycles, then low. No change on any output for 60 cycles.
- **Short press:** BTN[0] high for 40 cycles, then low.
  - BTN_LEVEL[0] rises 10–15 cycles after the rise.
  - Exactly one SHORT_PRESS[0] pulse, 10–15 cycles after the fall.
  - LONG_PRESS[0] stays 0.
- **Long press:** BTN[0] held for 80 cycles.
  - One LONG_PRESS[0] pulse, 36–40 cycles after BTN_LEVEL rises.
  - After release, BTN_LEVEL falls with no SHORT_PRESS.
- **Release bounce:** BTN[1] held; 20 cycles after BTN_LEVEL[1] rises, pull it low for 5 cycles, then high.
  - No SHORT_PRESS[1] pulse.
  - LONG_PRESS[1] still fires, delayed by at most 2 ticks.
- **Simultaneous and mid-operation reset:**
  - Release BTN=2'b11 on the same cycle after a 40-cycle hold: SHORT_PRESS=2'b11 pulses in the same cycle.
  - Assert RST_N=0 during a hold: no pulse is ever emitted for that press.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch button front-end: channel state encoding,
// prescaler derivation and button index constants.
package stopwatch_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS_DB  = 3'd1,
    HELD      = 3'd2,
    LONG_HELD = 3'd3,
    REL_DB    = 3'd4
  } ch_state_e;

  localparam int BTN_SS  = 0;
  localparam int BTN_LAP = 1;

  // Clock cycles per 1 ms tick.
  function automatic int tick_div(input int clk_freq);
    return clk_freq / 1000;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: two-flop synchroniser, debounce / short-long classification FSM
// and its debounce and hold counters. Advances only on the shared 1 ms tick.
module btn_channel
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 3000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tick_i,
  input  logic       btn_i,
  output logic       level_o,
  output logic       short_o,
  output logic       long_o,
  output logic [2:0] state_o
);

  localparam int DCW = $clog2(DEBOUNCE_MS) + 1;
  localparam int HCW = $clog2(LONG_MS) + 1;
  localparam logic [DCW-1:0] DC_LAST = DCW'(DEBOUNCE_MS - 1);
  localparam logic [HCW-1:0] HC_LAST = HCW'(LONG_MS - 1);

  logic           sync1_q, sync_q;
  ch_state_e      state_q, state_d;
  logic [DCW-1:0] dc_q, dc_d;
  logic [HCW-1:0] hc_q, hc_d;
  logic           long_flag_q, long_flag_d;
  logic           level_q, level_d;
  logic           short_q, short_d;
  logic           long_q, long_d;

  always_comb begin
    state_d     = state_q;
    dc_d        = dc_q;
    hc_d        = hc_q;
    long_flag_d = long_flag_q;
    level_d     = level_q;
    short_d     = 1'b0;
    long_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sync_q) begin
          state_d = PRESS_DB;
          dc_d    = '0;
        end
      end
      PRESS_DB: begin
        if (!sync_q) begin
          state_d = IDLE;
        end else if (tick_i) begin
          if (dc_q == DC_LAST) begin
            state_d = HELD;
            level_d = 1'b1;
            hc_d    = '0;
          end else begin
            dc_d = dc_q + 1'b1;
          end
        end
      end
      HELD: begin
        if (!sync_q) begin
          state_d     = REL_DB;
          long_flag_d = 1'b0;
          dc_d        = '0;
        end else if (tick_i) begin
          if (hc_q == HC_LAST) begin
            state_d = LONG_HELD;
            long_d  = 1'b1;
          end else begin
            hc_d = hc_q + 1'b1;
          end
        end
      end
      LONG_HELD: begin
        if (!sync_q) begin
          state_d     = REL_DB;
          long_flag_d = 1'b1;
          dc_d        = '0;
        end
      end
      REL_DB: begin
        // A bounce resumes the hold where it left off; hc is not touched here.
        if (sync_q) begin
          state_d = long_flag_q ? LONG_HELD : HELD;
        end else if (tick_i) begin
          if (dc_q == DC_LAST) begin
            state_d = IDLE;
            level_d = 1'b0;
            short_d = !long_flag_q;
          end else begin
            dc_d = dc_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q     <= 1'b0;
      sync_q      <= 1'b0;
      state_q     <= IDLE;
      dc_q        <= '0;
      hc_q        <= '0;
      long_flag_q <= 1'b0;
      level_q     <= 1'b0;
      short_q     <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      sync1_q     <= btn_i;
      sync_q      <= sync1_q;
      state_q     <= state_d;
      dc_q        <= dc_d;
      hc_q        <= hc_d;
      long_flag_q <= long_flag_d;
      level_q     <= level_d;
      short_q     <= short_d;
      long_q      <= long_d;
    end
  end

  assign level_o = level_q;
  assign short_o = short_q;
  assign long_o  = long_q;
  assign state_o = state_q;

endmodule

// File: rtl/btn_press_classifier.sv
// Two-button front-end for the stopwatch: shared 1 ms prescaler feeding two
// independent debounce/classify channels. STATE_DBG carries both channel states.
module btn_press_classifier
  import stopwatch_pkg::*;
#(
  parameter int CLK_FREQ    = 125_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 3000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [1:0] BTN,
  output logic [1:0] BTN_LEVEL,
  output logic [1:0] SHORT_PRESS,
  output logic [1:0] LONG_PRESS,
  output logic [5:0] STATE_DBG
);

  localparam int TICK_DIV = tick_div(CLK_FREQ);
  localparam int PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic          tick;

  assign tick  = (pre_q == P_LAST);
  assign pre_d = tick ? '0 : pre_q + 1'b1;

  always_ff @(posedge CLK) begin
    if (!RST_N) pre_q <= '0;
    else        pre_q <= pre_d;
  end

  btn_channel #(
    .DEBOUNCE_MS(DEBOUNCE_MS),
    .LONG_MS    (LONG_MS)
  ) u_ss (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .tick_i (tick),
    .btn_i  (BTN[BTN_SS]),
    .level_o(BTN_LEVEL[BTN_SS]),
    .short_o(SHORT_PRESS[BTN_SS]),
    .long_o (LONG_PRESS[BTN_SS]),
    .state_o(STATE_DBG[3*BTN_SS +: 3])
  );

  btn_channel #(
    .DEBOUNCE_MS(DEBOUNCE_MS),
    .LONG_MS    (LONG_MS)
  ) u_lap (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .tick_i (tick),
    .btn_i  (BTN[BTN_LAP]),
    .level_o(BTN_LEVEL[BTN_LAP]),
    .short_o(SHORT_PRESS[BTN_LAP]),
    .long_o (LONG_PRESS[BTN_LAP]),
    .state_o(STATE_DBG[3*BTN_LAP +: 3])
  );

endmodule

// File: tb/tb_btn_press_classifier.sv
// Directed bench for btn_press_classifier at TICK_DIV=4, DEBOUNCE_MS=3, LONG_MS=10.
module tb_btn_press_classifier;

  localparam int CLK_FREQ    = 4000;
  localparam int DEBOUNCE_MS = 3;
  localparam int LONG_MS     = 10;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] btn   = 2'b00;
  logic [1:0] btn_level, short_press, long_press;
  logic [5:0] state_dbg;

  btn_press_classifier #(
    .CLK_FREQ   (CLK_FREQ),
    .DEBOUNCE_MS(DEBOUNCE_MS),
    .LONG_MS    (LONG_MS)
  ) dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .BTN        (btn),
    .BTN_LEVEL  (btn_level),
    .SHORT_PRESS(short_press),
    .LONG_PRESS (long_press),
    .STATE_DBG  (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  // event monitor, sampled on the falling edge
  int short_cnt[2] = '{0, 0};
  int long_cnt[2]  = '{0, 0};
  int rise_cnt[2]  = '{0, 0};
  int fall_cnt[2]  = '{0, 0};
  int long_cyc[2]  = '{0, 0};
  int rise_cyc[2]  = '{0, 0};
  int wide_cnt = 0;
  int overlap_cnt = 0;
  int both_short_cnt = 0;
  logic [1:0] short_prev = 2'b00;
  logic [1:0] long_prev  = 2'b00;
  logic [1:0] level_prev = 2'b00;

  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (short_press[c]) short_cnt[c]++;
      if (long_press[c]) begin long_cnt[c]++; long_cyc[c] = cyc; end
      if (btn_level[c] && !level_prev[c]) begin rise_cnt[c]++; rise_cyc[c] = cyc; end
      if (!btn_level[c] && level_prev[c]) fall_cnt[c]++;
    end
    if (((short_press & short_prev) != 2'b00) || ((long_press & long_prev) != 2'b00)) wide_cnt++;
    if ((short_press & long_press) != 2'b00) overlap_cnt++;
    if (short_press == 2'b11) both_short_cnt++;
    short_prev = short_press;
    long_prev  = long_press;
    level_prev = btn_level;
  end

  // scoreboard: expected pulse counts per scenario {short1, short0, long1, long0}
  logic [7:0] exp_q[$];
  int snap_short[2], snap_long[2], snap_rise[2], snap_fall[2];

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int v, input int lo, input int hi);
    check($sformatf("%s (value %0d, allowed %0d..%0d)", tag, v, lo, hi), int'(v >= lo && v <= hi), 1);
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    for (int c = 0; c < 2; c++) begin
      snap_short[c] = short_cnt[c];
      snap_long[c]  = long_cnt[c];
      snap_rise[c]  = rise_cnt[c];
      snap_fall[c]  = fall_cnt[c];
    end
  endtask

  task automatic expect_pulses(input int s1, input int s0, input int l1, input int l0);
    exp_q.push_back({2'(s1), 2'(s0), 2'(l1), 2'(l0)});
  endtask

  task automatic score(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 0, 1);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_short1"}, short_cnt[1] - snap_short[1], int'(e[7:6]));
    check({tag, "_short0"}, short_cnt[0] - snap_short[0], int'(e[5:4]));
    check({tag, "_long1"},  long_cnt[1]  - snap_long[1],  int'(e[3:2]));
    check({tag, "_long0"},  long_cnt[0]  - snap_long[0],  int'(e[1:0]));
  endtask

  // Called right after driving BTN; latency counts edges from that point.
  task automatic wait_level(input int ch, input logic v, input int limit, output int lat);
    int start;
    start = cyc;
    lat = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (btn_level[ch] == v) begin
        lat = cyc - start;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int start;
    int both_snap;

    // reset with both buttons held
    snap();
    expect_pulses(1, 1, 0, 0);
    btn = 2'b11;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_level", int'(btn_level), 0);
    check("rst_short", int'(short_press), 0);
    check("rst_long", int'(long_press), 0);
    check("rst_state", int'(state_dbg), 0);
    step();
    rst_n = 1'b1;
    wait_level(0, 1'b1, 30, lat);
    check_range("rst_redebounce_lat", lat, 10, 15);
    check("rst_both_level", int'(btn_level), 3);
    step();
    btn = 2'b00;
    wait_level(0, 1'b0, 30, lat);
    repeat (10) step();
    score("rst_press");

    // glitch rejection
    snap();
    expect_pulses(0, 0, 0, 0);
    btn = 2'b01;
    repeat (6) step();
    btn = 2'b00;
    repeat (60) step();
    check("glitch_rise0", rise_cnt[0] - snap_rise[0], 0);
    check("glitch_level", int'(btn_level), 0);
    score("glitch");

    // short press on BTN0
    snap();
    expect_pulses(0, 1, 0, 0);
    btn = 2'b01;
    start = cyc;
    wait_level(0, 1'b1, 30, lat);
    check_range("short_rise_lat", lat, 10, 15);
    while (cyc < start + 40) step();
    btn = 2'b00;
    wait_level(0, 1'b0, 30, lat);
    check_range("short_fall_lat", lat, 10, 15);
    check("short_with_fall", int'(short_press[0]), 1);
    repeat (10) step();
    score("short");

    // long press on BTN0
    snap();
    expect_pulses(0, 0, 0, 1);
    btn = 2'b01;
    start = cyc;
    wait_level(0, 1'b1, 30, lat);
    check_range("long_rise_lat", lat, 10, 15);
    while (cyc < start + 80) step();
    check("long_level_held", int'(btn_level[0]), 1);
    check_range("long_lat", long_cyc[0] - rise_cyc[0], 36, 40);
    btn = 2'b00;
    wait_level(0, 1'b0, 30, lat);
    check_range("long_fall_lat", lat, 10, 15);
    check("long_no_short_at_fall", int'(short_press[0]), 0);
    repeat (10) step();
    score("long");

    // release bounce on BTN1
    snap();
    expect_pulses(0, 0, 1, 0);
    btn = 2'b10;
    wait_level(1, 1'b1, 30, lat);
    check_range("bounce_rise_lat", lat, 10, 15);
    repeat (20) step();
    btn = 2'b00;
    repeat (5) step();
    btn = 2'b10;
    lat = -1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (long_press[1]) begin
        lat = cyc - rise_cyc[1];
        break;
      end
    end
    check_range("bounce_long_lat", lat, 36, 48);
    check("bounce_level_held", int'(btn_level[1]), 1);
    step();
    btn = 2'b00;
    wait_level(1, 1'b0, 30, lat);
    repeat (10) step();
    check("bounce_single_fall", fall_cnt[1] - snap_fall[1], 1);
    score("bounce");

    // simultaneous release on both channels
    snap();
    expect_pulses(1, 1, 0, 0);
    both_snap = both_short_cnt;
    btn = 2'b11;
    repeat (40) step();
    btn = 2'b00;
    wait_level(0, 1'b0, 30, lat);
    check("simul_short_both", int'(short_press), 3);
    repeat (10) step();
    check("simul_both_cycles", both_short_cnt - both_snap, 1);
    score("simul");

    // reset in the middle of a hold
    snap();
    expect_pulses(0, 0, 0, 0);
    btn = 2'b01;
    repeat (30) step();
    check("midrst_level_before", int'(btn_level[0]), 1);
    rst_n = 1'b0;
    btn = 2'b00;
    step();
    step();
    check("midrst_level_cleared", int'(btn_level), 0);
    rst_n = 1'b1;
    repeat (80) step();
    check("midrst_level_after", int'(btn_level), 0);
    score("midrst");

    check("pulse_width_one_cycle", wide_cnt, 0);
    check("short_long_exclusive", overlap_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
